seq_detect_param: RTL and testbench



---
 rtl/seq_detect_pkg.sv | 31 +++
 rtl/seq_detect_param_sat_counter.sv | 27 ++
 rtl/seq_detect_param.sv | 116 +++++++++++
 tb/tb_seq_detect_param.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parametrised serial-pattern detector.
package seq_detect_pkg;

    // Largest pattern length the window-compare helper supports
    localparam int unsigned MAX_LEN_LIMIT = 32;

    // Default configuration of the detector
    localparam int unsigned DEF_MAX_LEN   = 8;
    localparam int unsigned LEN_W         = $clog2(DEF_MAX_LEN + 1);
    localparam int unsigned CMP_LEN_W     = $clog2(MAX_LEN_LIMIT + 1);

    // Pattern and length loaded at reset (the legacy "11001" detector)
    localparam logic [DEF_MAX_LEN-1:0] SD_DEFAULT_PAT = 8'b0001_1001;
    localparam int unsigned            SD_DEFAULT_LEN = 5;

    // Compare the low len bits of the window against the low len bits of the pattern
    function automatic logic win_match(
        input logic [MAX_LEN_LIMIT-1:0] win,
        input logic [MAX_LEN_LIMIT-1:0] pat,
        input logic [CMP_LEN_W-1:0]     len
    );
        logic [MAX_LEN_LIMIT-1:0] mask;
        if (len >= CMP_LEN_W'(MAX_LEN_LIMIT)) begin
            mask = '1;
        end else begin
            mask = (MAX_LEN_LIMIT'(1) << len) - MAX_LEN_LIMIT'(1);
        end
        return ((win ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count up on i_inc, stick at all-ones, clear has priority
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detect_param.sv
// Run-time loadable Mealy serial-pattern detector with overlap control,
// input-valid qualifier, registered match copy and saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned             MAX_LEN     = DEF_MAX_LEN,
    parameter int unsigned             CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]      DEFAULT_PAT = MAX_LEN'(SD_DEFAULT_PAT),
    parameter int unsigned             DEFAULT_LEN = SD_DEFAULT_LEN
) (
    input  logic                             CLK,
    input  logic                             RESET_N,
    input  logic                             in,
    input  logic                             in_valid,
    input  logic                             pat_load,
    input  logic [MAX_LEN-1:0]               pat_in,
    input  logic [$clog2(MAX_LEN+1)-1:0]     len_in,
    input  logic                             overlap_en,
    input  logic                             clear_cnt,
    output logic                             out,
    output logic                             out_q,
    output logic [CNT_W-1:0]                 match_cnt,
    output logic                             cfg_err
);

    localparam int unsigned W_LEN = $clog2(MAX_LEN + 1);

    // Architectural state
    logic [MAX_LEN-1:0] r_pat;
    logic [W_LEN-1:0]   r_len;
    logic [MAX_LEN-2:0] r_hist;
    logic [W_LEN-1:0]   r_fill;
    logic               r_out_q;
    logic               r_cfg_err;

    // Next-state and decode wires
    logic [MAX_LEN-1:0] w_pat_nxt;
    logic [W_LEN-1:0]   w_len_nxt;
    logic [MAX_LEN-2:0] w_hist_nxt;
    logic [W_LEN-1:0]   w_fill_nxt;
    logic [MAX_LEN-1:0] w_win;
    logic [W_LEN-1:0]   w_len_m1;
    logic               w_load_ok;
    logic               w_load_bad;
    logic               w_hit;
    logic               w_out;

    // A load is only accepted for 1 <= len_in <= MAX_LEN
    assign w_load_ok  = pat_load && (len_in != '0) && (len_in <= W_LEN'(MAX_LEN));
    assign w_load_bad = pat_load && !w_load_ok;

    // Window is the stored history with the current bit appended as newest
    assign w_win    = {r_hist, in};
    assign w_len_m1 = r_len - W_LEN'(1);
    assign w_hit    = win_match(MAX_LEN_LIMIT'(w_win), MAX_LEN_LIMIT'(r_pat), CMP_LEN_W'(r_len));

    // Mealy match: needs a full window, a qualified bit and no load in flight
    assign w_out = RESET_N && in_valid && !pat_load && (r_fill >= w_len_m1) && w_hit;
    assign out   = w_out;

    // Next-state for pattern, length, history and fill level
    always_comb begin
        w_pat_nxt  = r_pat;
        w_len_nxt  = r_len;
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        if (w_load_ok) begin
            // Accepted load restarts detection; the bit of this cycle is dropped
            w_pat_nxt  = pat_in;
            w_len_nxt  = len_in;
            w_hist_nxt = '0;
            w_fill_nxt = '0;
        end else if (in_valid) begin
            w_hist_nxt = w_win[MAX_LEN-2:0];
            if (w_out && !overlap_en) begin
                w_fill_nxt = '0;
            end else if (r_fill < w_len_m1) begin
                w_fill_nxt = r_fill + W_LEN'(1);
            end
        end
    end

    // Detector state registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pat     <= DEFAULT_PAT;
            r_len     <= W_LEN'(DEFAULT_LEN);
            r_hist    <= '0;
            r_fill    <= '0;
            r_out_q   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_pat     <= w_pat_nxt;
            r_len     <= w_len_nxt;
            r_hist    <= w_hist_nxt;
            r_fill    <= w_fill_nxt;
            r_out_q   <= w_out;
            r_cfg_err <= w_load_bad;
        end
    end

    assign out_q   = r_out_q;
    assign cfg_err = r_cfg_err;

    // Match counter
    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .i_inc   (w_out),
        .i_clr   (clear_cnt),
        .o_cnt   (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (narrow counter to reach saturation).
module tb_seq_detect_param;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned LW      = $clog2(MAX_LEN + 1);

    logic               CLK;
    logic               RESET_N;
    logic               in;
    logic               in_valid;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LW-1:0]      len_in;
    logic               overlap_en;
    logic               clear_cnt;
    logic               out;
    logic               out_q;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    int n_checks = 0;
    int n_pass   = 0;

    seq_detect_param #(
        .MAX_LEN     (MAX_LEN),
        .CNT_W       (CNT_W),
        .DEFAULT_PAT (8'b0001_1001),
        .DEFAULT_LEN (5)
    ) u_dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .in         (in),
        .in_valid   (in_valid),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .len_in     (len_in),
        .overlap_en (overlap_en),
        .clear_cnt  (clear_cnt),
        .out        (out),
        .out_q      (out_q),
        .match_cnt  (match_cnt),
        .cfg_err    (cfg_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs at the falling edge, then settle
    task automatic drive(input logic b, input logic v, input logic ld, input logic clr);
        @(negedge CLK);
        in        = b;
        in_valid  = v;
        pat_load  = ld;
        clear_cnt = clr;
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; in = 1'b1; in_valid = 1'b1; pat_load = 1'b0;
        pat_in = '0; len_in = '0; overlap_en = 1'b0; clear_cnt = 1'b0;
        #12;
        n_checks++; if (out !== 1'b0) $display("FAIL reset_out got %b exp 0", out); else n_pass++;
        n_checks++; if (out_q !== 1'b0) $display("FAIL reset_out_q got %b exp 0", out_q); else n_pass++;
        n_checks++; if (match_cnt !== 2'd0) $display("FAIL reset_cnt got %0d exp 0", match_cnt); else n_pass++;
        n_checks++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err got %b exp 0", cfg_err); else n_pass++;
        @(negedge CLK);
        RESET_N = 1'b1; in_valid = 1'b0; in = 1'b0;
    endtask

    task automatic test_default_stream();
        logic [9:0] bits;
        logic [9:0] expo;
        bits = 10'b1100111001;
        expo = 10'b0000100001;
        for (int i = 9; i >= 0; i--) begin
            drive(bits[i], 1'b1, 1'b0, 1'b0);
            n_checks++; if (out !== expo[i]) $display("FAIL dflt_out bit%0d got %b exp %b", 10 - i, out, expo[i]); else n_pass++;
            @(posedge CLK); #1;
            n_checks++; if (out_q !== expo[i]) $display("FAIL dflt_out_q bit%0d got %b exp %b", 10 - i, out_q, expo[i]); else n_pass++;
        end
        n_checks++; if (match_cnt !== 2'd2) $display("FAIL dflt_cnt got %0d exp 2", match_cnt); else n_pass++;
    endtask

    task automatic test_overlap();
        logic [4:0] bits;
        logic [4:0] exp_ov;
        logic [4:0] exp_no;
        bits   = 5'b10101;
        exp_ov = 5'b00101;
        exp_no = 5'b00100;
        // Load 101/3 with overlap, clearing the counter in the same cycle
        pat_in = 8'b0000_0101; len_in = 4'd3; overlap_en = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (out !== 1'b0) $display("FAIL ovl_load_out got %b exp 0", out); else n_pass++;
        @(posedge CLK); #1;
        n_checks++; if (cfg_err !== 1'b0) $display("FAIL ovl_load_cfg_err got %b exp 0", cfg_err); else n_pass++;
        for (int i = 4; i >= 0; i--) begin
            drive(bits[i], 1'b1, 1'b0, 1'b0);
            n_checks++; if (out !== exp_ov[i]) $display("FAIL ovl_out bit%0d got %b exp %b", 5 - i, out, exp_ov[i]); else n_pass++;
        end
        @(posedge CLK); #1;
        n_checks++; if (match_cnt !== 2'd2) $display("FAIL ovl_cnt got %0d exp 2", match_cnt); else n_pass++;
        // Reload to flush history, non-overlapping this time
        overlap_en = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (out !== 1'b0) $display("FAIL novl_load_out got %b exp 0", out); else n_pass++;
        for (int i = 4; i >= 0; i--) begin
            drive(bits[i], 1'b1, 1'b0, 1'b0);
            n_checks++; if (out !== exp_no[i]) $display("FAIL novl_out bit%0d got %b exp %b", 5 - i, out, exp_no[i]); else n_pass++;
        end
        @(posedge CLK); #1;
        n_checks++; if (match_cnt !== 2'd1) $display("FAIL novl_cnt got %0d exp 1", match_cnt); else n_pass++;
    endtask

    task automatic test_valid_gaps();
        logic [7:0] bits;
        logic [7:0] vals;
        logic [7:0] expo;
        bits = 8'b11010001;
        vals = 8'b11000111;
        expo = 8'b00000001;
        pat_in = 8'b0001_1001; len_in = 4'd5;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            drive(bits[i], vals[i], 1'b0, 1'b0);
            n_checks++; if (out !== expo[i]) $display("FAIL gap_out step%0d got %b exp %b", 8 - i, out, expo[i]); else n_pass++;
            @(posedge CLK); #1;
            n_checks++; if (out_q !== expo[i]) $display("FAIL gap_out_q step%0d got %b exp %b", 8 - i, out_q, expo[i]); else n_pass++;
        end
        n_checks++; if (match_cnt !== 2'd1) $display("FAIL gap_cnt got %0d exp 1", match_cnt); else n_pass++;
    endtask

    task automatic test_cfg_err();
        logic [4:0] bits;
        logic [4:0] expo;
        bits = 5'b11001;
        expo = 5'b00001;
        pat_in = 8'b0000_0101; len_in = 4'd0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (out !== 1'b0) $display("FAIL cfg0_out got %b exp 0", out); else n_pass++;
        @(posedge CLK); #1;
        n_checks++; if (cfg_err !== 1'b1) $display("FAIL cfg0_err got %b exp 1", cfg_err); else n_pass++;
        len_in = 4'd9;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge CLK); #1;
        n_checks++; if (cfg_err !== 1'b1) $display("FAIL cfg9_err got %b exp 1", cfg_err); else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        n_checks++; if (cfg_err !== 1'b0) $display("FAIL cfg_pulse_end got %b exp 0", cfg_err); else n_pass++;
        // Pattern must still be 11001
        for (int i = 4; i >= 0; i--) begin
            drive(bits[i], 1'b1, 1'b0, 1'b0);
            n_checks++; if (out !== expo[i]) $display("FAIL cfg_keep_out bit%0d got %b exp %b", 5 - i, out, expo[i]); else n_pass++;
        end
        @(posedge CLK); #1;
        n_checks++; if (match_cnt !== 2'd2) $display("FAIL cfg_keep_cnt got %0d exp 2", match_cnt); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        // Single-bit pattern '1' so every valid 1 is a hit
        pat_in = 8'b0000_0001; len_in = 4'd1; overlap_en = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (out !== 1'b0) $display("FAIL sat_load_out got %b exp 0", out); else n_pass++;
        @(posedge CLK); #1;
        n_checks++; if (match_cnt !== 2'd0) $display("FAIL sat_clear got %0d exp 0", match_cnt); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            n_checks++; if (out !== 1'b1) $display("FAIL sat_out hit%0d got %b exp 1", i + 1, out); else n_pass++;
            @(posedge CLK); #1;
            n_checks++; if (match_cnt !== exp_cnt[i]) $display("FAIL sat_cnt hit%0d got %0d exp %0d", i + 1, match_cnt, exp_cnt[i]); else n_pass++;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++; if (out !== 1'b1) $display("FAIL clr_hit_out got %b exp 1", out); else n_pass++;
        @(posedge CLK); #1;
        n_checks++; if (match_cnt !== 2'd0) $display("FAIL clr_prio_cnt got %0d exp 0", match_cnt); else n_pass++;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (out !== 1'b0) $display("FAIL len1_zero_out got %b exp 0", out); else n_pass++;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge CLK); #1;
        n_checks++; if (match_cnt !== 2'd1) $display("FAIL len1_cnt got %0d exp 1", match_cnt); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [3:0] pre;
        logic [5:0] post;
        logic [5:0] expo;
        pre  = 4'b1100;
        post = 6'b111001;
        expo = 6'b000001;
        pat_in = 8'b0001_1001; len_in = 4'd5;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            drive(pre[i], 1'b1, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (out !== 1'b1) $display("FAIL prerst_out got %b exp 1", out); else n_pass++;
        // Reset lands before the edge that would have counted the hit
        #1; RESET_N = 1'b0; #1;
        n_checks++; if (out !== 1'b0) $display("FAIL inrst_out got %b exp 0", out); else n_pass++;
        n_checks++; if (match_cnt !== 2'd0) $display("FAIL inrst_cnt got %0d exp 0", match_cnt); else n_pass++;
        @(posedge CLK); #1;
        n_checks++; if (out_q !== 1'b0) $display("FAIL inrst_out_q got %b exp 0", out_q); else n_pass++;
        n_checks++; if (out !== 1'b0) $display("FAIL inrst_out2 got %b exp 0", out); else n_pass++;
        @(negedge CLK);
        RESET_N = 1'b1; in = post[5]; in_valid = 1'b1; #1;
        n_checks++; if (out !== expo[5]) $display("FAIL postrst_out bit1 got %b exp %b", out, expo[5]); else n_pass++;
        for (int i = 4; i >= 0; i--) begin
            drive(post[i], 1'b1, 1'b0, 1'b0);
            n_checks++; if (out !== expo[i]) $display("FAIL postrst_out bit%0d got %b exp %b", 6 - i, out, expo[i]); else n_pass++;
        end
        @(posedge CLK); #1;
        n_checks++; if (out_q !== 1'b1) $display("FAIL postrst_out_q got %b exp 1", out_q); else n_pass++;
        n_checks++; if (match_cnt !== 2'd1) $display("FAIL postrst_cnt got %0d exp 1", match_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_overlap();
        test_valid_gaps();
        test_cfg_err();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
